// File: rtl/evt_sort_queue_pkg.sv
// Shared widths and key helper for the sorted event queue.
package evt_sort_queue_pkg;
    localparam int DATA_W    = 16;
    localparam int KEY_W     = 14;
    localparam int ID_W      = 2;
    localparam int DEPTH_DEF = 16;

    typedef logic [DATA_W-1:0] evt_t;
    typedef logic [KEY_W-1:0]  key_t;

    // Timestamp key sits above the LP id; ordering looks at the key only.
    function automatic key_t evt_key(evt_t e);
        return e[ID_W +: KEY_W];
    endfunction
endpackage

// File: rtl/evt_sort_queue_if.sv
// Enqueue/dequeue handshake and status bus for evt_sort_queue.
interface evt_sort_queue_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              enq;
    logic              deq;
    logic [DATA_W-1:0] inp_data;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              ovf_err;
    logic              udf_err;

    modport master (
        output enq, deq, inp_data,
        input  out_data, count, full, empty, ovf_err, udf_err
    );

    modport slave (
        input  enq, deq, inp_data,
        output out_data, count, full, empty, ovf_err, udf_err
    );
endinterface

// File: rtl/evt_sort_queue_cell.sv
// One slot of the sorted array: picks its next entry from itself, a
// neighbour or the new event, steered by the thermometer compare bits.
module evt_sort_cell #(
    parameter int DATA_W  = 16,
    parameter bit IS_HEAD = 1'b0
) (
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] below,
    input  logic [DATA_W-1:0] above,
    input  logic [DATA_W-1:0] new_ent,
    input  logic              do_ins,
    input  logic              do_shift,
    input  logic              cmp_lo,    // thermometer bit of slot below (0 at head)
    input  logic              cmp_self,  // 1: new key goes at or below this slot
    input  logic              cmp_hi,    // thermometer bit of slot above (1 past top)
    output logic [DATA_W-1:0] nxt
);
    // Next-entry select; with shift+insert the array is viewed one slot lower.
    always_comb begin
        nxt = cur;
        unique case ({do_ins, do_shift})
            2'b10: begin
                if (!cmp_self)    nxt = cur;
                else if (!cmp_lo) nxt = new_ent;
                else              nxt = below;
            end
            2'b01: nxt = above;
            2'b11: begin
                if (IS_HEAD ? cmp_hi : (cmp_hi & ~cmp_self)) nxt = new_ent;
                else if (cmp_self)                           nxt = cur;
                else                                         nxt = above;
            end
            default: nxt = cur;
        endcase
    end
endmodule

// File: rtl/evt_sort_queue.sv
// Sorted event queue: register array with slot 0 as the smallest key,
// single-cycle insert/remove chosen by a parallel thermometer compare.
module evt_sort_queue
    import evt_sort_queue_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = evt_sort_queue_pkg::DATA_W
) (
    input  logic CLK,
    input  logic rst_n,
    evt_sort_queue_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][DATA_W-1:0] slot_q, slot_d;
    logic [DEPTH+1:0][DATA_W-1:0] ext;     // zero-padded neighbours
    logic [DEPTH+1:0]             thermo;  // 0 at bottom, 1 past the top
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         full_q, empty_q, ovf_q, udf_q;
    logic                         do_ins, do_shift;
    key_t                         new_key;

    assign new_key  = evt_key(bus.inp_data);
    // A deq on a full queue frees the slot the enq needs.
    assign do_shift = bus.deq & ~empty_q;
    assign do_ins   = bus.enq & (~full_q | do_shift);

    assign ext[0]          = '0;
    assign ext[DEPTH+1]    = '0;
    assign thermo[0]       = 1'b0;
    assign thermo[DEPTH+1] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_slot
            assign ext[g+1] = slot_q[g];
            // Strict greater-than so equal keys stay in arrival order;
            // empty slots always compare as "larger".
            assign thermo[g+1] = (CNT_W'(g) >= cnt_q) ||
                                 (evt_key(slot_q[g]) > new_key);

            evt_sort_cell #(.DATA_W(DATA_W), .IS_HEAD(g == 0)) u_cell (
                .cur      (slot_q[g]),
                .below    (ext[g]),
                .above    (ext[g+2]),
                .new_ent  (bus.inp_data),
                .do_ins   (do_ins),
                .do_shift (do_shift),
                .cmp_lo   (thermo[g]),
                .cmp_self (thermo[g+1]),
                .cmp_hi   (thermo[g+2]),
                .nxt      (slot_d[g])
            );
        end
    endgenerate

    assign cnt_d = cnt_q + CNT_W'(do_ins) - CNT_W'(do_shift);

    // Array, count, flags and sticky errors; all outputs come from here.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            slot_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(DEPTH));
            empty_q <= (cnt_d == '0);
            if (bus.enq && full_q && !bus.deq) ovf_q <= 1'b1;
            if (bus.deq && empty_q)            udf_q <= 1'b1;
        end
    end

    assign bus.out_data = slot_q[0];
    assign bus.count    = cnt_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.ovf_err  = ovf_q;
    assign bus.udf_err  = udf_q;
endmodule

// File: tb/tb_evt_sort_queue.sv
// Scoreboard bench for evt_sort_queue against a queue-based reference model.
module tb_evt_sort_queue;
    import evt_sort_queue_pkg::*;

    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int CW    = 5;

    typedef struct packed {
        logic [DW-1:0] out;
        logic [CW-1:0] cnt;
        logic          full;
        logic          empty;
        logic          ovf;
        logic          udf;
    } exp_t;

    logic CLK = 1'b0;
    logic rst_n;
    always #5 CLK = ~CLK;

    evt_sort_queue_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    evt_sort_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [DW-1:0] mq[$];
    bit            m_ovf, m_udf;
    exp_t          sb[$];
    int            n_chk  = 0;
    int            n_fail = 0;

    function automatic logic [DW-1:0] ev(int k, int id);
        return {14'(k), 2'(id)};
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: ordered list; pop front, then insert after all keys <= new.
    function automatic void model_step(bit r, bit e, bit d, logic [DW-1:0] data);
        int pos;
        if (!r) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
            return;
        end
        if (d) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else               m_udf = 1;
        end
        if (e) begin
            if (mq.size() < DEPTH) begin
                pos = mq.size();
                for (int k = 0; k < mq.size(); k++)
                    if (evt_key(mq[k]) > evt_key(data)) begin pos = k; break; end
                mq.insert(pos, data);
            end else begin
                m_ovf = 1;
            end
        end
    endfunction

    task automatic cycle(bit r, bit e, bit d, logic [DW-1:0] data);
        exp_t x;
        rst_n        = r;
        bus.enq      = e;
        bus.deq      = d;
        bus.inp_data = data;
        @(posedge CLK);
        model_step(r, e, d, data);
        x.out   = (mq.size() > 0) ? mq[0] : '0;
        x.cnt   = CW'(mq.size());
        x.full  = (mq.size() == DEPTH);
        x.empty = (mq.size() == 0);
        x.ovf   = m_ovf;
        x.udf   = m_udf;
        sb.push_back(x);
        #1;
        bus.enq = 1'b0;
        bus.deq = 1'b0;
    endtask

    // Monitor: every edge yields one expected state, compared mid-cycle.
    always @(negedge CLK) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(x.out));
            chk("count",    32'(bus.count),    32'(x.cnt));
            chk("full",     32'(bus.full),     32'(x.full));
            chk("empty",    32'(bus.empty),    32'(x.empty));
            chk("ovf_err",  32'(bus.ovf_err),  32'(x.ovf));
            chk("udf_err",  32'(bus.udf_err),  32'(x.udf));
        end
    end

    initial begin
        rst_n = 1'b0; bus.enq = 1'b0; bus.deq = 1'b0; bus.inp_data = '0;

        // Reset state
        cycle(0, 1, 1, ev(9, 0));
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_out",   32'(bus.out_data), 0);

        // Arrival order kept for equal keys
        cycle(1, 1, 0, ev(40, 0));
        cycle(1, 1, 0, ev(10, 1));
        cycle(1, 1, 0, ev(25, 2));
        cycle(1, 1, 0, ev(10, 3));
        chk("ord_count", 32'(bus.count), 4);
        chk("ord_head0", 32'(bus.out_data), 32'(ev(10, 1)));
        cycle(1, 0, 1, '0);
        chk("ord_head1", 32'(bus.out_data), 32'(ev(10, 3)));
        cycle(1, 0, 1, '0);
        chk("ord_head2", 32'(bus.out_data), 32'(ev(25, 2)));
        cycle(1, 0, 1, '0);
        chk("ord_head3", 32'(bus.out_data), 32'(ev(40, 0)));
        cycle(1, 0, 1, '0);
        chk("ord_empty", 32'(bus.empty), 1);

        // Overflow drop when full
        cycle(0, 0, 0, '0);
        for (int k = 1; k <= 16; k++) cycle(1, 1, 0, ev(k, 0));
        cycle(1, 1, 0, ev(0, 0));
        chk("ovf_flag", 32'(bus.ovf_err), 1);
        chk("ovf_full", 32'(bus.full), 1);
        chk("ovf_head", 32'(bus.out_data), 32'(ev(1, 0)));

        // Enq+deq while full
        cycle(1, 1, 1, ev(5, 1));
        chk("swap_count", 32'(bus.count), 16);
        chk("swap_head",  32'(bus.out_data), 32'(ev(2, 0)));
        cycle(1, 0, 1, '0);
        cycle(1, 0, 1, '0);
        chk("swap_k4",  32'(bus.out_data), 32'(ev(4, 0)));
        cycle(1, 0, 1, '0);
        chk("swap_k5a", 32'(bus.out_data), 32'(ev(5, 0)));
        cycle(1, 0, 1, '0);
        chk("swap_k5b", 32'(bus.out_data), 32'(ev(5, 1)));
        cycle(1, 0, 1, '0);
        chk("swap_k6",  32'(bus.out_data), 32'(ev(6, 0)));

        // Underflow, then enq+deq on empty
        cycle(0, 0, 0, '0);
        cycle(1, 0, 1, '0);
        chk("udf_flag",  32'(bus.udf_err), 1);
        chk("udf_count", 32'(bus.count), 0);
        chk("udf_out",   32'(bus.out_data), 0);
        cycle(1, 1, 1, ev(7, 2));
        chk("ed_count", 32'(bus.count), 1);
        chk("ed_head",  32'(bus.out_data), 32'(ev(7, 2)));

        // Reset mid-operation discards contents and errors
        for (int k = 0; k < 3; k++) cycle(1, 1, 0, ev(20 + k, 0));
        cycle(0, 1, 0, ev(1, 0));
        chk("mrst_count", 32'(bus.count), 0);
        chk("mrst_empty", 32'(bus.empty), 1);
        chk("mrst_out",   32'(bus.out_data), 0);
        chk("mrst_udf",   32'(bus.udf_err), 0);
        cycle(1, 1, 0, ev(3, 1));
        chk("mrst_head", 32'(bus.out_data), 32'(ev(3, 1)));

        // Random traffic with duplicate-heavy keys and rare resets
        for (int n = 0; n < 10000; n++) begin
            bit r, e, d;
            r = ($urandom_range(0, 999) != 0);
            e = ($urandom_range(0, 99) < 55);
            d = ($urandom_range(0, 99) < 45);
            cycle(r, e, d, ev($urandom_range(0, 40), $urandom_range(0, 3)));
        end

        repeat (2) @(negedge CLK);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
